// File: rtl/handle_advance_state_sync.sv
// handle_advance_state_sync
// Two-board agreement on a game-state advance. The initiating board sends an
// advance message, waits for the interboard sender to finish, then waits for an
// ACK with a timeout and a bounded number of retransmissions. The responding
// board ACKs a received advance message. Both sides pulse advance_state once per
// agreed advance and return to IDLE, so one instance serves every transition.
// Player ids: P1 = 0, P2 = 1. Only PLAYER == MASTER may initiate.
// If both boards send an advance at the same time, the initiator treats the
// incoming advance as its ACK.

module handle_advance_state_sync #(
   parameter int          PLAYER         = 0,
   parameter int          MASTER         = 0,
   parameter logic [15:0] ADV_STATE_MASK = 16'h0000,
   parameter logic [3:0]  ADV_MSG_TYPE   = 4'h3,
   parameter logic [3:0]  ACK_MSG_TYPE   = 4'hF,
   parameter int          TIMEOUT_CYC    = 1000,
   parameter int          MAX_RETRY      = 3,
   localparam int         RETRY_W        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1,
   localparam int         TIMER_W        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               interboard_rst,
   input  logic               start_game,
   input  logic [3:0]         cur_game_state,
   input  logic               inter_ready,
   input  logic               interboard_en,
   input  logic [3:0]         interboard_msg_type,
   output logic               advance_state,
   output logic               adv_err,
   output logic [RETRY_W-1:0] retry_cnt,
   output logic               advance_state_ctrl_en,
   output logic [3:0]         advance_state_ctrl_msg_type,
   output logic               advance_state_ctrl_move_dir,
   output logic [4:0]         advance_state_ctrl_block_x,
   output logic [2:0]         advance_state_ctrl_block_y,
   output logic [5:0]         advance_state_ctrl_card,
   output logic [2:0]         advance_state_ctrl_sel_len
);

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      SEND_ADV     = 3'd1,
      WAIT_RDY_ADV = 3'd2,
      WAIT_ACK     = 3'd3,
      SEND_ACK     = 3'd4,
      WAIT_RDY_ACK = 3'd5,
      FIN          = 3'd6,
      ERR          = 3'd7
   } state_t;

   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);
   localparam logic               IS_MASTER  = (PLAYER == MASTER) ? 1'b1 : 1'b0;

   state_t             state_r;
   logic [TIMER_W-1:0] timer_r;
   logic               rx_adv_s;
   logic               rx_ack_s;
   logic               can_init_s;

   // Decode of the received-message strobe and of the local initiation permission.
   assign rx_adv_s   = interboard_en && (interboard_msg_type == ADV_MSG_TYPE);
   assign rx_ack_s   = interboard_en && (interboard_msg_type == ACK_MSG_TYPE);
   assign can_init_s = IS_MASTER && ADV_STATE_MASK[cur_game_state];

   // Fields of the control message that this handler never uses.
   assign advance_state_ctrl_move_dir = 1'b0;
   assign advance_state_ctrl_block_x  = 5'd0;
   assign advance_state_ctrl_block_y  = 3'd0;
   assign advance_state_ctrl_card     = 6'd0;
   assign advance_state_ctrl_sel_len  = 3'd0;

   // Handshake FSM; outputs are registered and set on entry to the state that owns them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r                     <= IDLE;
         timer_r                     <= '0;
         retry_cnt                   <= '0;
         advance_state               <= 1'b0;
         adv_err                     <= 1'b0;
         advance_state_ctrl_en       <= 1'b0;
         advance_state_ctrl_msg_type <= 4'h0;
      end else if (interboard_rst) begin
         state_r                     <= IDLE;
         timer_r                     <= '0;
         retry_cnt                   <= '0;
         advance_state               <= 1'b0;
         adv_err                     <= 1'b0;
         advance_state_ctrl_en       <= 1'b0;
         advance_state_ctrl_msg_type <= 4'h0;
      end else begin
         advance_state         <= 1'b0;
         advance_state_ctrl_en <= 1'b0;
         case (state_r)
            IDLE: begin
               // A peer request wins over our own so both sides cannot stall.
               if (rx_adv_s) begin
                  state_r                     <= SEND_ACK;
                  advance_state_ctrl_en       <= 1'b1;
                  advance_state_ctrl_msg_type <= ACK_MSG_TYPE;
               end else if (can_init_s && start_game) begin
                  state_r                     <= SEND_ADV;
                  advance_state_ctrl_en       <= 1'b1;
                  advance_state_ctrl_msg_type <= ADV_MSG_TYPE;
                  retry_cnt                   <= '0;
               end else begin
                  state_r <= IDLE;
               end
            end
            SEND_ADV: begin
               state_r <= WAIT_RDY_ADV;
            end
            WAIT_RDY_ADV: begin
               if (inter_ready) begin
                  state_r <= WAIT_ACK;
                  timer_r <= '0;
               end else begin
                  state_r <= WAIT_RDY_ADV;
               end
            end
            WAIT_ACK: begin
               // An advance from the peer here is a collision and counts as its ACK.
               if (rx_ack_s || rx_adv_s) begin
                  state_r       <= FIN;
                  advance_state <= 1'b1;
               end else if (timer_r == TIMER_LAST) begin
                  if (retry_cnt < RETRY_MAX) begin
                     state_r                     <= SEND_ADV;
                     advance_state_ctrl_en       <= 1'b1;
                     advance_state_ctrl_msg_type <= ADV_MSG_TYPE;
                     retry_cnt                   <= retry_cnt + RETRY_W'(1);
                  end else begin
                     state_r <= ERR;
                     adv_err <= 1'b1;
                  end
               end else begin
                  timer_r <= timer_r + TIMER_W'(1);
               end
            end
            SEND_ACK: begin
               state_r <= WAIT_RDY_ACK;
            end
            WAIT_RDY_ACK: begin
               if (inter_ready) begin
                  state_r       <= FIN;
                  advance_state <= 1'b1;
               end else begin
                  state_r <= WAIT_RDY_ACK;
               end
            end
            FIN: begin
               state_r <= IDLE;
            end
            ERR: begin
               // Dead until a reset; the error flag stays raised.
               state_r <= ERR;
               adv_err <= 1'b1;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_handle_advance_state_sync.sv
// Scoreboard bench for handle_advance_state_sync: a master instance (PLAYER==MASTER,
// mask bit 0) and a responder instance (PLAYER!=MASTER), both with TIMEOUT_CYC=8 and
// MAX_RETRY=2. Stimulus pushes expected ctrl_en / advance_state events into
// per-instance queues; a negedge monitor pops and compares them.

module tb_handle_advance_state_sync;

   localparam logic [3:0] ADV   = 4'h3;
   localparam logic [3:0] ACK   = 4'hF;
   localparam logic [3:0] OTHER = 4'h2;

   typedef struct packed {
      logic       kind;   // 0: ctrl_en pulse, 1: advance_state pulse
      logic [3:0] msg;
      logic [1:0] rc;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ib_rst;
   logic [3:0] gs;
   logic [1:0] start_v, rdy_v, en_v;
   logic [3:0] msg_v [2];

   logic [1:0] adv_o, err_o, cen_o, md_o;
   logic [3:0] cmsg_o [2];
   logic [1:0] rc_o [2];
   logic [4:0] bx_o [2];
   logic [2:0] by_o [2];
   logic [5:0] card_o [2];
   logic [2:0] sl_o [2];

   ev_t q0[$];
   ev_t q1[$];
   int  n_checks = 0;
   int  n_fail   = 0;
   logic [1:0] prev_cen = 2'b00;
   logic [1:0] prev_adv = 2'b00;

   always #5 clk = ~clk;

   handle_advance_state_sync #(
      .PLAYER(0), .MASTER(0), .ADV_STATE_MASK(16'h0001), .ADV_MSG_TYPE(ADV),
      .ACK_MSG_TYPE(ACK), .TIMEOUT_CYC(8), .MAX_RETRY(2)
   ) u_master (
      .clk(clk), .rst_n(rst_n), .interboard_rst(ib_rst), .start_game(start_v[0]),
      .cur_game_state(gs), .inter_ready(rdy_v[0]), .interboard_en(en_v[0]),
      .interboard_msg_type(msg_v[0]), .advance_state(adv_o[0]), .adv_err(err_o[0]),
      .retry_cnt(rc_o[0]), .advance_state_ctrl_en(cen_o[0]),
      .advance_state_ctrl_msg_type(cmsg_o[0]), .advance_state_ctrl_move_dir(md_o[0]),
      .advance_state_ctrl_block_x(bx_o[0]), .advance_state_ctrl_block_y(by_o[0]),
      .advance_state_ctrl_card(card_o[0]), .advance_state_ctrl_sel_len(sl_o[0])
   );

   handle_advance_state_sync #(
      .PLAYER(1), .MASTER(0), .ADV_STATE_MASK(16'h0001), .ADV_MSG_TYPE(ADV),
      .ACK_MSG_TYPE(ACK), .TIMEOUT_CYC(8), .MAX_RETRY(2)
   ) u_slave (
      .clk(clk), .rst_n(rst_n), .interboard_rst(ib_rst), .start_game(start_v[1]),
      .cur_game_state(gs), .inter_ready(rdy_v[1]), .interboard_en(en_v[1]),
      .interboard_msg_type(msg_v[1]), .advance_state(adv_o[1]), .adv_err(err_o[1]),
      .retry_cnt(rc_o[1]), .advance_state_ctrl_en(cen_o[1]),
      .advance_state_ctrl_msg_type(cmsg_o[1]), .advance_state_ctrl_move_dir(md_o[1]),
      .advance_state_ctrl_block_x(bx_o[1]), .advance_state_ctrl_block_y(by_o[1]),
      .advance_state_ctrl_card(card_o[1]), .advance_state_ctrl_sel_len(sl_o[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_ev(input int i, input logic kind, input logic [3:0] msg, input logic [1:0] rc);
      ev_t e;
      e.kind = kind;
      e.msg  = msg;
      e.rc   = rc;
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic pop_ev(input int i, output ev_t e, output bit ok);
      ok = 1'b0;
      e  = '0;
      if (i == 0) begin
         if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      end else begin
         if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      end
   endtask

   task automatic mon_one(input int i);
      ev_t e;
      bit  ok;
      if (cen_o[i] === 1'b1) begin
         chk($sformatf("d%0d ctrl_en not back-to-back", i), {31'd0, prev_cen[i]}, 32'd0);
         pop_ev(i, e, ok);
         chk($sformatf("d%0d ctrl_en expected", i), {31'd0, ok}, 32'd1);
         if (ok) begin
            chk($sformatf("d%0d event kind (ctrl)", i), {31'd0, e.kind}, 32'd0);
            chk($sformatf("d%0d ctrl msg_type", i), {28'd0, cmsg_o[i]}, {28'd0, e.msg});
         end
      end
      if (adv_o[i] === 1'b1) begin
         chk($sformatf("d%0d advance_state single pulse", i), {31'd0, prev_adv[i]}, 32'd0);
         pop_ev(i, e, ok);
         chk($sformatf("d%0d advance_state expected", i), {31'd0, ok}, 32'd1);
         if (ok) begin
            chk($sformatf("d%0d event kind (adv)", i), {31'd0, e.kind}, 32'd1);
            chk($sformatf("d%0d retry_cnt at advance", i), {30'd0, rc_o[i]}, {30'd0, e.rc});
         end
      end
   endtask

   // Monitor: compares every DUT output event against the scoreboard queues.
   always @(negedge clk) begin
      mon_one(0);
      mon_one(1);
      prev_cen <= cen_o;
      prev_adv <= adv_o;
   end

   task automatic cycn(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_rdy(input int i);
      rdy_v[i] = 1'b1;
      @(negedge clk);
      rdy_v[i] = 1'b0;
   endtask

   task automatic rx(input int i, input logic [3:0] m);
      en_v[i]  = 1'b1;
      msg_v[i] = m;
      @(negedge clk);
      en_v[i]  = 1'b0;
      msg_v[i] = 4'h0;
   endtask

   // Local request on the master; returns at the start of the first WAIT_ACK cycle.
   task automatic initiate();
      push_ev(0, 1'b0, ADV, 2'd0);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      chk("request->ctrl_en latency", {31'd0, cen_o[0]}, 32'd1);
      @(negedge clk);
      pulse_rdy(0);
   endtask

   // Waits (bounded) for the retransmission and checks how many cycles it took.
   task automatic wait_retx(input int exp_n);
      int n = 0;
      push_ev(0, 1'b0, ADV, 2'd0);
      while (cen_o[0] !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("retransmit seen", {31'd0, cen_o[0]}, 32'd1);
      chk("cycles to retransmit", n, exp_n);
      @(negedge clk);
      pulse_rdy(0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; ib_rst = 1'b0; gs = 4'd0;
      start_v = 2'b00; rdy_v = 2'b00; en_v = 2'b00;
      msg_v[0] = 4'h0; msg_v[1] = 4'h0;
      #12;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("d%0d reset outputs", i),
             {25'd0, adv_o[i], err_o[i], cen_o[i], rc_o[i], md_o[i]}, 32'd0);
         chk($sformatf("d%0d reset ctrl fields", i),
             {4'd0, cmsg_o[i], bx_o[i], by_o[i], card_o[i], sl_o[i]}, 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      cycn(2);

      // Test 1: master advance, ACK on first wait.
      initiate();
      push_ev(0, 1'b1, 4'h0, 2'd0);
      rx(0, ACK);
      @(negedge clk);
      chk("t1 back to idle, no err", {31'd0, err_o[0]}, 32'd0);
      cycn(2);

      // Test 2: master acting as responder to a peer advance.
      push_ev(0, 1'b0, ACK, 2'd0);
      rx(0, ADV);
      @(negedge clk);
      push_ev(0, 1'b1, 4'h0, 2'd0);
      pulse_rdy(0);
      cycn(2);

      // Masked-off state: start_game must not initiate.
      gs = 4'd1;
      start_v[0] = 1'b1;
      cycn(5);
      start_v[0] = 1'b0;
      gs = 4'd0;
      cycn(1);

      // Non-master: never initiates, but ACKs a received advance.
      start_v[1] = 1'b1;
      cycn(5);
      start_v[1] = 1'b0;
      push_ev(1, 1'b0, ACK, 2'd0);
      rx(1, ADV);
      chk("slave ACK latency", {31'd0, cen_o[1]}, 32'd1);
      @(negedge clk);
      push_ev(1, 1'b1, 4'h0, 2'd0);
      pulse_rdy(1);
      cycn(2);

      // Test 5: collision in WAIT_ACK counts as ACK, no ACK sent.
      initiate();
      cycn(2);
      push_ev(0, 1'b1, 4'h0, 2'd0);
      rx(0, ADV);
      cycn(3);

      // Test 4: unrelated msg ignored, one retransmit, ACK in second wait.
      initiate();
      cycn(2);
      rx(0, OTHER);
      wait_retx(5);
      cycn(3);
      push_ev(0, 1'b1, 4'h0, 2'd1);
      rx(0, ACK);
      chk("t4 retry_cnt held", {30'd0, rc_o[0]}, 32'd1);
      chk("t4 adv_err clear", {31'd0, err_o[0]}, 32'd0);
      cycn(2);

      // Test 3: no ACK at all -> two retransmits then ERR.
      initiate();
      wait_retx(8);
      wait_retx(8);
      cycn(7);
      chk("t3 adv_err before last timeout", {31'd0, err_o[0]}, 32'd0);
      cycn(1);
      chk("t3 adv_err set", {31'd0, err_o[0]}, 32'd1);
      chk("t3 retry_cnt final", {30'd0, rc_o[0]}, 32'd2);
      start_v[0] = 1'b1;
      rx(0, ADV);
      pulse_rdy(0);
      rx(0, ACK);
      cycn(3);
      start_v[0] = 1'b0;
      chk("t3 adv_err sticky", {31'd0, err_o[0]}, 32'd1);

      // Test 6b: interboard_rst clears ERR.
      ib_rst = 1'b1;
      @(negedge clk);
      ib_rst = 1'b0;
      chk("ib_rst clears adv_err", {31'd0, err_o[0]}, 32'd0);
      chk("ib_rst clears retry_cnt", {30'd0, rc_o[0]}, 32'd0);
      cycn(2);

      // Test 6a: asynchronous reset mid-WAIT_ACK with retry_cnt=1.
      initiate();
      wait_retx(8);
      cycn(2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async reset retry_cnt", {30'd0, rc_o[0]}, 32'd0);
      chk("async reset outputs", {29'd0, adv_o[0], err_o[0], cen_o[0]}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cycn(2);

      // After reset the master is idle and usable again.
      initiate();
      push_ev(0, 1'b1, 4'h0, 2'd0);
      rx(0, ACK);
      cycn(3);

      chk("master scoreboard drained", q0.size(), 32'd0);
      chk("slave scoreboard drained", q1.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
